pkg_parse: RTL and testbench
============================

// Module: pkg_parse
// PURPOSE
// - UART-RX-side word assembler; the receive counterpart of the TX packetiser.
// - Collects received bytes LSB-first into 32-bit words and presents each word on a valid/ready output.
// - Discards partial words after an inter-byte timeout. Flags overrun when a word completes while the output is still held.
// - Sits between the UART byte receiver and the command/data consumer.
// PARAMETERS
// - TMO_CYC  default 16'd52080  idle clk cycles allowed between bytes of one word (>=2)
// - TMO_W    default 16         width of timeout counter; TMO_CYC < 2**TMO_W
// PORTS
// - clk              in   1   system clock; all logic on posedge
// - rst_n            in   1   asynchronous, active-low reset
// - i_urtrx_dat      in   8   received UART byte
// - i_urtrx_vld      in   1   1-cycle strobe: i_urtrx_dat valid
// - i_rx_flush       in   1   sync clear of partial word and output register
// - o_rx_data        out  32  assembled word; byte0 -> [7:0] ... byte3 -> [31:24]
// - o_rx_data_vld    out  1   word held and valid; stays high until accepted
// - i_rx_data_rdy    in   1   consumer accepts when o_rx_data_vld & i_rx_data_rdy
// - o_rx_busy        out  1   high while a partial word (1..3 bytes) is collected
// - o_rx_tmo         out  1   1-cycle pulse: partial word discarded on timeout
// - o_rx_ovf         out  1   1-cycle pulse: completed word dropped, output still held
// BEHAVIOUR
// - Reset (rst_n=0, async): all outputs 0; byte_cnt=0; tmo_cnt=0; shift reg=0.
// - Collector FSM
//   - IDLE (byte_cnt=0): vld -> store byte in [7:0], byte_cnt=1, go COLLECT.
//   - COLLECT: vld stores byte at lane byte_cnt and increments byte_cnt.
//   - On the 4th byte, byte_cnt returns to 0 and the word completes.
// - Completion: word written to o_rx_data; o_rx_data_vld=1 on the cycle after the edge that sampled the 4th vld (latency 1).
// - Output handshake
//   - o_rx_data / o_rx_data_vld are stable while vld=1 and rdy=0.
//   - vld&rdy clears vld next cycle.
//   - Completion in the same cycle as vld&rdy loads the new word; vld stays 1 (no bubble).
// - Overrun: a word completes while vld=1 and rdy=0.
//   - The new word is dropped and the held word is kept.
//   - o_rx_ovf pulses 1 cycle; the collector returns to IDLE.
// - Timeout
//   - tmo_cnt clears on every accepted byte and increments each cycle in COLLECT without vld.
//   - When tmo_cnt==TMO_CYC-1 and no vld: partial word discarded, byte_cnt=0, o_rx_tmo pulses, IDLE.
//   - A vld arriving on that same cycle wins: the byte is stored and no timeout occurs.
// - o_rx_busy = (byte_cnt!=0), registered; it is 0 in IDLE.
// - i_rx_flush (highest priority after reset):
//   - Next cycle: byte_cnt=0, tmo_cnt=0, o_rx_data_vld=0.
//   - A vld in the flush cycle is ignored; no tmo/ovf pulse.
// - Reset mid-word or with a held word: everything is cleared immediately; no pulses are generated.
// - Gaps between bytes are arbitrary (< TMO_CYC); back-to-back vld every cycle is supported.
// TESTING
// - Bytes 78,56,34,12 (gaps of 10 cycles), rdy=1 -> o_rx_data=32'h12345678, vld pulse 1 cycle, one cycle after the 4th strobe.
// - Two words back-to-back (vld every cycle), rdy=0 until the 2nd completes -> 1st word held, o_rx_ovf=1 once, then rdy -> 1st word accepted.
// - TMO_CYC=20: bytes AA,BB then 20 idle -> o_rx_tmo pulse, busy=0. Then 01,02,03,04 -> 32'h04030201.
// - TMO_CYC=20: 3rd byte lands exactly at tmo_cnt=19 -> no timeout; word completes normally.
// - rst_n low after 2 bytes, release, then 4 bytes 11,22,33,44 -> 32'h44332211, no stale bytes.
// - i_rx_flush with 3 bytes pending and a word held -> vld=0, busy=0 next cycle; no tmo or ovf pulse.

Source files
------------

// File: rtl/pkg_parse.sv
// UART-RX word assembler: packs received bytes LSB-first into 32-bit words and
// presents them on a valid/ready output, with inter-byte timeout and overrun reporting.
module pkg_parse #(
    parameter int               TMO_W   = 16,
    parameter logic [TMO_W-1:0] TMO_CYC = 16'd52080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_urtrx_dat,
    input  logic        i_urtrx_vld,
    input  logic        i_rx_flush,
    output logic [31:0] o_rx_data,
    output logic        o_rx_data_vld,
    input  logic        i_rx_data_rdy,
    output logic        o_rx_busy,
    output logic        o_rx_tmo,
    output logic        o_rx_ovf
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - 1'b1;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic [31:0]      data_q, data_d;
    logic             vld_q, vld_d;
    logic             busy_q, busy_d;
    logic             tmo_q, tmo_d;
    logic             ovf_q, ovf_d;

    // Output handshake: a word is transferred on any cycle where o_rx_data_vld
    // and i_rx_data_rdy are both high; while vld is high and rdy is low, the
    // data and vld hold steady. A new word may load on the transfer cycle.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        vld_d      = vld_q & ~i_rx_data_rdy;
        tmo_d      = 1'b0;
        ovf_d      = 1'b0;

        if (i_rx_flush) begin
            state_d    = ST_IDLE;
            byte_cnt_d = 2'd0;
            tmo_cnt_d  = '0;
            data_d     = '0;
            vld_d      = 1'b0;
        end else if (i_urtrx_vld) begin
            tmo_cnt_d = '0;
            shreg_d[{byte_cnt_q, 3'b000} +: 8] = i_urtrx_dat;
            if (byte_cnt_q == 2'd3) begin
                state_d    = ST_IDLE;
                byte_cnt_d = 2'd0;
                // A held word that is not being taken this cycle wins over the new one.
                if (vld_q && !i_rx_data_rdy) begin
                    ovf_d = 1'b1;
                end else begin
                    data_d = shreg_d;
                    vld_d  = 1'b1;
                end
            end else begin
                state_d    = ST_COLLECT;
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end else if (state_q == ST_COLLECT) begin
            if (tmo_cnt_q == TMO_LAST) begin
                state_d    = ST_IDLE;
                byte_cnt_d = 2'd0;
                tmo_cnt_d  = '0;
                tmo_d      = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end

        busy_d = (byte_cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            tmo_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_rx_data     = data_q;
    assign o_rx_data_vld = vld_q;
    assign o_rx_busy     = busy_q;
    assign o_rx_tmo      = tmo_q;
    assign o_rx_ovf      = ovf_q;

endmodule

// File: tb/tb_pkg_parse.sv
// Bench for pkg_parse: table of per-cycle vectors plus hand sequences for
// gapped bytes, overrun, timeout boundary, reset and flush.
module tb_pkg_parse;

    localparam int         TMO_W   = 8;
    localparam logic [7:0] TMO_CYC = 8'd20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_urtrx_dat;
    logic        i_urtrx_vld;
    logic        i_rx_flush;
    logic        i_rx_data_rdy;
    logic [31:0] o_rx_data;
    logic        o_rx_data_vld;
    logic        o_rx_busy;
    logic        o_rx_tmo;
    logic        o_rx_ovf;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        f;
        logic [31:0] e_data;
        logic        e_vld;
        logic        e_busy;
        logic        e_tmo;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[16];

    pkg_parse #(.TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_urtrx_dat   (i_urtrx_dat),
        .i_urtrx_vld   (i_urtrx_vld),
        .i_rx_flush    (i_rx_flush),
        .o_rx_data     (o_rx_data),
        .o_rx_data_vld (o_rx_data_vld),
        .i_rx_data_rdy (i_rx_data_rdy),
        .o_rx_busy     (o_rx_busy),
        .o_rx_tmo      (o_rx_tmo),
        .o_rx_ovf      (o_rx_ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] e_data, input logic e_vld,
                           input logic e_busy, input logic e_tmo, input logic e_ovf);
        chk({name, ".vld"},  {31'd0, o_rx_data_vld}, {31'd0, e_vld});
        chk({name, ".busy"}, {31'd0, o_rx_busy},     {31'd0, e_busy});
        chk({name, ".tmo"},  {31'd0, o_rx_tmo},      {31'd0, e_tmo});
        chk({name, ".ovf"},  {31'd0, o_rx_ovf},      {31'd0, e_ovf});
        if (e_vld) chk({name, ".data"}, o_rx_data, e_data);
    endtask

    // driver: apply inputs for one cycle, sample 1 time unit after the edge
    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
        i_urtrx_vld   = v;
        i_urtrx_dat   = d;
        i_rx_data_rdy = r;
        i_rx_flush    = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, r, 1'b0);
    endtask

    // scoreboard: every transfer must match the next expected word
    always @(negedge clk) begin
        if (rst_n && o_rx_data_vld && i_rx_data_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL accept: got unexpected word %h expected none", o_rx_data);
            end else begin
                chk("accept", o_rx_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        i_urtrx_vld = 1'b0; i_urtrx_dat = 8'h00; i_rx_data_rdy = 1'b0; i_rx_flush = 1'b0;

        //              v     d      r     f     e_data        vld   busy  tmo   ovf
        tbl[0]  = '{1'b1, 8'h78, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h56, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h34, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h12, 1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 32'hA4A3A2A1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'hA4A3A2A1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'hB1, 1'b0, 1'b0, 32'hA4A3A2A1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'hB2, 1'b0, 1'b0, 32'hA4A3A2A1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'hB3, 1'b0, 1'b0, 32'hA4A3A2A1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 8'hB4, 1'b1, 1'b0, 32'hB4B3B2B1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'hB4B3B2B1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst.data", o_rx_data, 32'h0);
        chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // table: back-to-back word, held word, no-bubble reload
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hA4A3A2A1);
        exp_q.push_back(32'hB4B3B2B1);
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk_out($sformatf("tbl%0d", i), tbl[i].e_data, tbl[i].e_vld,
                    tbl[i].e_busy, tbl[i].e_tmo, tbl[i].e_ovf);
        end

        // gapped bytes, 10 idle cycles between strobes
        exp_q.push_back(32'h12345678);
        step(1'b1, 8'h78, 1'b1, 1'b0); idle(10, 1'b1);
        chk_out("gap.mid", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h56, 1'b1, 1'b0); idle(10, 1'b1);
        step(1'b1, 8'h34, 1'b1, 1'b0); idle(10, 1'b1);
        step(1'b1, 8'h12, 1'b1, 1'b0);
        chk_out("gap.done", 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_out("gap.pulse", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // overrun: two words back-to-back with rdy low
        exp_q.push_back(32'h14131211);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        chk_out("ovf.w1", 32'h14131211, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h15 + 8'(i), 1'b0, 1'b0);
        chk_out("ovf.pre", 32'h14131211, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h18, 1'b0, 1'b0);
        chk_out("ovf.hit", 32'h14131211, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_out("ovf.once", 32'h14131211, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_out("ovf.acc", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // timeout after exactly TMO_CYC idle cycles
        exp_q.push_back(32'h04030201);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        step(1'b1, 8'hBB, 1'b1, 1'b0);
        idle(19, 1'b1);
        chk_out("tmo.edge", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        chk_out("tmo.hit", 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        chk_out("tmo.pulse", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01 + 8'(i), 1'b1, 1'b0);
        chk_out("tmo.word", 32'h04030201, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);

        // byte arriving on the last allowed cycle wins over the timeout
        exp_q.push_back(32'h24232221);
        step(1'b1, 8'h21, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        idle(19, 1'b1);
        step(1'b1, 8'h23, 1'b1, 1'b0);
        chk_out("bnd.byte3", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h24, 1'b1, 1'b0);
        chk_out("bnd.word", 32'h24232221, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);

        // async reset with a held word and a partial word
        for (int i = 0; i < 4; i++) step(1'b1, 8'h51 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h61, 1'b0, 1'b0);
        step(1'b1, 8'h62, 1'b0, 1'b0);
        chk_out("rst2.pre", 32'h54535251, 1'b1, 1'b1, 1'b0, 1'b0);
        i_urtrx_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2.data", o_rx_data, 32'h0);
        chk_out("rst2", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h44332211);
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        chk_out("rst2.word", 32'h44332211, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);

        // flush with a held word and 3 pending bytes; strobe in flush cycle ignored
        for (int i = 0; i < 4; i++) step(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0);
        chk_out("fl.pre", 32'h34333231, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        chk_out("fl.now", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk_out("fl.after", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h04030201);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01 + 8'(i), 1'b1, 1'b0);
        chk_out("fl.word", 32'h04030201, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);

        chk("exp_q.left", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
